prefetch_fill: RTL and testbench

PREFETCH_FILL -- requirements
Module: prefetch_fill

---
 rtl/prefetch_fill.sv | 135 +++++++++++++
 tb/tb_prefetch_fill.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_fill.sv
// prefetch_fill: fetches 16-bit words from cs:ip and streams the bytes, in address order, into the instruction fifo.
// A flush (load_new_ip) restarts fetching at a new address. A read still in flight when the flush arrives
// is allowed to complete, and its data is discarded.
module prefetch_fill (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] new_cs,
    input  logic [15:0] new_ip,
    input  logic        load_new_ip,
    output logic        fifo_wr_en,
    output logic [7:0]  fifo_wr_data,
    input  logic        fifo_full,
    output logic        fifo_reset,
    output logic        mem_access,
    output logic [18:0] mem_address,
    input  logic        mem_ack,
    input  logic [15:0] mem_data
);

    localparam int unsigned SEG_W  = 16;
    localparam int unsigned PHYS_W = 20;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t              r_state;
    logic [SEG_W-1:0]    r_cs;
    logic [SEG_W-1:0]    r_ip;
    logic [7:0]          r_lo;
    logic [7:0]          r_hi;
    logic [1:0]          r_cnt;
    logic                r_access;

    logic [PHYS_W-1:0]   w_phys;
    logic                w_ack_ok;
    logic                w_wr;

    // Physical address of the next byte to fetch (20-bit wrap)
    always_comb begin
        w_phys   = {r_cs, 4'b0000} + PHYS_W'(r_ip);
        w_ack_ok = r_access & mem_ack;
        w_wr     = (r_state == S_DRAIN) & (r_cnt != 2'd0) & ~fifo_full & ~load_new_ip;
    end

    assign mem_address  = w_phys[PHYS_W-1:1];
    assign mem_access   = r_access;
    assign fifo_reset   = load_new_ip;
    assign fifo_wr_en   = w_wr;
    assign fifo_wr_data = r_lo;

    // Fetch/drain/abort sequencing, fetch pointer and held bytes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_cs     <= 16'hFFFF;
            r_ip     <= 16'h0000;
            r_lo     <= 8'h00;
            r_hi     <= 8'h00;
            r_cnt    <= 2'd0;
            r_access <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (load_new_ip) begin
                        r_cs  <= new_cs;
                        r_ip  <= new_ip;
                        r_cnt <= 2'd0;
                        if (r_access && !mem_ack) begin
                            // Read still outstanding: wait for it and drop the data
                            r_state  <= S_ABORT;
                            r_access <= 1'b1;
                        end else begin
                            r_state  <= S_FETCH;
                            r_access <= ~w_ack_ok;
                        end
                    end else if (w_ack_ok) begin
                        r_access <= 1'b0;
                        r_state  <= S_DRAIN;
                        if (w_phys[0]) begin
                            // Odd address: only the high byte belongs to the stream
                            r_lo  <= mem_data[15:8];
                            r_cnt <= 2'd1;
                            r_ip  <= r_ip + 16'd1;
                        end else begin
                            r_lo  <= mem_data[7:0];
                            r_hi  <= mem_data[15:8];
                            r_cnt <= 2'd2;
                            r_ip  <= r_ip + 16'd2;
                        end
                    end else begin
                        // Covers the first cycle after reset or after an ack
                        r_access <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (load_new_ip) begin
                        r_cs     <= new_cs;
                        r_ip     <= new_ip;
                        r_cnt    <= 2'd0;
                        r_state  <= S_FETCH;
                        r_access <= 1'b1;
                    end else if (w_wr) begin
                        if (r_cnt == 2'd1) begin
                            r_cnt    <= 2'd0;
                            r_state  <= S_FETCH;
                            r_access <= 1'b1;
                        end else begin
                            r_cnt <= 2'd1;
                            r_lo  <= r_hi;
                        end
                    end
                end
                S_ABORT: begin
                    if (load_new_ip) begin
                        r_cs <= new_cs;
                        r_ip <= new_ip;
                    end
                    if (mem_ack) begin
                        r_state  <= S_FETCH;
                        r_access <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_FETCH;
                    r_access <= 1'b0;
                    r_cnt    <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prefetch_fill.sv
// Bench for prefetch_fill: a memory responder plus a byte-stream reference model.
// The model states that each fifo byte must be the memory byte at the next linear cs:ip address.
module tb_prefetch_fill;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] new_cs, new_ip;
    logic        load_new_ip;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        fifo_full;
    logic        fifo_reset;
    logic        mem_access;
    logic [18:0] mem_address;
    logic        mem_ack;
    logic [15:0] mem_data;

    prefetch_fill dut (
        .clk          (clk),
        .reset        (rst_n),
        .new_cs       (new_cs),
        .new_ip       (new_ip),
        .load_new_ip  (load_new_ip),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .fifo_reset   (fifo_reset),
        .mem_access   (mem_access),
        .mem_address  (mem_address),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Counted comparison; reports any mismatch
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory contents: explicit preloads, otherwise a fixed hash of the address
    logic [7:0] mem_pre [int];
    function automatic logic [7:0] mem_byte(input logic [19:0] a);
        if (mem_pre.exists(int'(a))) return mem_pre[int'(a)];
        return 8'(a ^ (a >> 7) ^ (a >> 13) ^ 20'h0005A);
    endfunction

    // Reference model: the linear byte pointer
    logic [15:0] m_cs, m_ip;
    function automatic logic [19:0] m_phys();
        return {m_cs, 4'b0000} + 20'(m_ip);
    endfunction

    // Driver and responder state
    bit          manual, drv_ack, drv_load, drv_full, rand_delays, aborted;
    logic [15:0] drv_cs, drv_ip;
    int          wait_cnt, ack_delay, cyc, total_wr;
    bit          prev_acc, prev_ack, s_rise, s_ack, s_wr, s_frst;
    logic [7:0]  wr_log[$];
    int          wr_cyc[$];

    // One clock cycle: drive on the falling edge, then check and update the model
    task automatic step();
        logic        acc;
        logic [18:0] a;
        @(negedge clk);
        acc = mem_access;
        a   = mem_address;
        if (manual) mem_ack = drv_ack;
        else if (acc) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                if (rand_delays) ack_delay = int'($urandom_range(0, 4));
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
        mem_data = {mem_byte({a, 1'b1}), mem_byte({a, 1'b0})};
        if (aborted || drv_load) mem_data = ~mem_data;
        load_new_ip = drv_load;
        new_cs      = drv_cs;
        new_ip      = drv_ip;
        fifo_full   = drv_full;
        #1;
        check_eq("fifo_reset", fifo_reset, load_new_ip);
        check_eq("wr_blocked", fifo_wr_en & (load_new_ip | fifo_full), 0);
        if (prev_acc && !prev_ack) check_eq("access_held", acc, 1);
        if (prev_acc && prev_ack)  check_eq("access_drop", acc, 0);
        if (acc && mem_ack && !aborted && !load_new_ip)
            check_eq("ack_addr", a, 32'(m_phys() >> 1));
        if (fifo_wr_en) begin
            check_eq("wr_byte", fifo_wr_data, mem_byte(m_phys()));
            m_ip = m_ip + 16'd1;
            wr_log.push_back(fifo_wr_data);
            wr_cyc.push_back(cyc);
            total_wr++;
        end
        if (load_new_ip) begin
            m_cs = new_cs;
            m_ip = new_ip;
        end
        if (!acc) aborted = 1'b0;
        else if (load_new_ip && !mem_ack) aborted = 1'b1;
        s_rise   = acc && !prev_acc;
        s_ack    = acc && mem_ack;
        s_wr     = fifo_wr_en;
        s_frst   = fifo_reset;
        prev_acc = acc;
        prev_ack = mem_ack;
        cyc++;
    endtask

    task automatic step_load(input logic [15:0] cs, input logic [15:0] ip);
        drv_load = 1'b1; drv_cs = cs; drv_ip = ip;
        step();
        drv_load = 1'b0;
    endtask

    task automatic wait_rise(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            ok = s_rise;
        end
        if (!ok) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_ack(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            ok = s_ack;
        end
        if (!ok) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_wr(input string tag, input int n);
        bit ok = (wr_log.size() >= n);
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            ok = (wr_log.size() >= n);
        end
        if (!ok) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    task automatic clear_log();
        wr_log.delete();
        wr_cyc.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; load_new_ip = 1'b0; new_cs = '0; new_ip = '0;
        fifo_full = 1'b0; mem_ack = 1'b0; mem_data = '0;
        manual = 0; drv_ack = 0; drv_load = 0; drv_full = 0; drv_cs = '0; drv_ip = '0;
        rand_delays = 0; aborted = 0; wait_cnt = 0; ack_delay = 2; cyc = 0; total_wr = 0;
        prev_acc = 0; prev_ack = 0;
        m_cs = 16'hFFFF; m_ip = 16'h0000;
        mem_pre[32'hFFFF0] = 8'hEA; mem_pre[32'hFFFF1] = 8'h90;
        mem_pre[32'h00100] = 8'h12; mem_pre[32'h00101] = 8'h34;
        mem_pre[32'hFFFFE] = 8'hA5; mem_pre[32'hFFFFF] = 8'h5A;

        // Reset state
        #12;
        check_eq("rst_access", mem_access, 0);
        check_eq("rst_addr", mem_address, 19'h7FFF8);
        check_eq("rst_wr_en", fifo_wr_en, 0);
        check_eq("rst_wr_data", fifo_wr_data, 8'h00);

        // Boot fetch: ack on the third access cycle, even word drains low then high
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        step();
        check_eq("boot_access_rise", s_rise, 1);
        check_eq("boot_addr", mem_address, 19'h7FFF8);
        wait_wr("boot_wr", 2);
        if (wr_log.size() >= 2) begin
            check_eq("boot_byte0", wr_log[0], 8'hEA);
            check_eq("boot_byte1", wr_log[1], 8'h90);
            check_eq("boot_consec", wr_cyc[1] - wr_cyc[0], 1);
        end
        wait_rise("boot_next");
        check_eq("boot_next_addr", mem_address, 19'h7FFF9);

        // Odd start address: only the high byte is written
        step_load(16'h0000, 16'h0101);
        clear_log();
        wait_rise("odd_rise");
        check_eq("odd_addr", mem_address, 19'h00080);
        wait_wr("odd_wr", 1);
        wait_rise("odd_next");
        check_eq("odd_next_addr", mem_address, 19'h00081);
        check_eq("odd_count", wr_log.size(), 1);
        if (wr_log.size() >= 1) check_eq("odd_byte", wr_log[0], 8'h34);

        // ip wrap with fifo_full stalling the drain for 5 cycles
        step_load(16'hF000, 16'hFFFE);
        clear_log();
        wait_rise("wrap_rise");
        check_eq("wrap_addr", mem_address, 19'h7FFFF);
        wait_ack("wrap_ack");
        drv_full = 1'b1;
        repeat (5) step();
        check_eq("wrap_stall", wr_log.size(), 0);
        drv_full = 1'b0;
        wait_wr("wrap_wr", 2);
        if (wr_log.size() >= 2) begin
            check_eq("wrap_byte0", wr_log[0], 8'hA5);
            check_eq("wrap_byte1", wr_log[1], 8'h5A);
        end
        wait_rise("wrap_next");
        check_eq("wrap_next_addr", mem_address, 19'h78000);

        // Flush during a read; ack four cycles later
        manual = 1; drv_ack = 0;
        clear_log();
        step_load(16'h1234, 16'h0010);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("abort_access", mem_access, 1);
        end
        drv_ack = 1; step(); drv_ack = 0;
        step();
        check_eq("abort_drop", mem_access, 0);
        manual = 0;
        wait_rise("abort_next");
        check_eq("abort_next_addr", mem_address, 19'h091A8);
        check_eq("abort_no_wr", wr_log.size(), 0);

        // Flush in the ack cycle
        manual = 1; drv_ack = 1;
        clear_log();
        step_load(16'h2000, 16'h0003);
        drv_ack = 0;
        check_eq("ackflush_frst", s_frst, 1);
        wait_rise("ackflush_rise");
        check_eq("ackflush_addr", mem_address, 19'h10001);
        check_eq("ackflush_no_wr", wr_log.size(), 0);

        // Flush during a drain while one byte is held
        drv_ack = 1; step(); drv_ack = 0;
        drv_full = 1'b1;
        repeat (2) step();
        drv_full = 1'b0;
        step_load(16'h3000, 16'h0040);
        check_eq("drainflush_frst", s_frst, 1);
        check_eq("drainflush_no_wr", wr_log.size(), 0);
        manual = 0;
        wait_rise("drainflush_rise");
        check_eq("drainflush_addr", mem_address, 19'h18020);
        wait_wr("drainflush_wr", 2);

        // Random traffic
        rand_delays = 1;
        total_wr = 0;
        for (int i = 0; i < 3000; i++) begin
            drv_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 59) == 0) step_load(16'($urandom), 16'($urandom));
            else step();
        end
        drv_full = 1'b0;
        check_eq("rand_progress", total_wr > 200, 1);

        // Asynchronous reset mid-traffic, then a late ack that must be ignored
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_access", mem_access, 0);
        check_eq("arst_addr", mem_address, 19'h7FFF8);
        check_eq("arst_wr_en", fifo_wr_en, 0);
        check_eq("arst_wr_data", fifo_wr_data, 8'h00);
        mem_ack = 1'b0;
        m_cs = 16'hFFFF; m_ip = 16'h0000;
        prev_acc = 0; prev_ack = 0; wait_cnt = 0; aborted = 1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        clear_log();
        manual = 1; drv_ack = 1;
        step();
        check_eq("late_ack_acc", mem_access, 0);
        drv_ack = 0;
        step();
        check_eq("late_ack_rise", s_rise, 1);
        check_eq("late_ack_addr", mem_address, 19'h7FFF8);
        manual = 0;
        for (int i = 0; i < 500; i++) begin
            drv_full = ($urandom_range(0, 3) == 0);
            step();
        end
        if (wr_log.size() >= 2) begin
            check_eq("post_rst_byte0", wr_log[0], 8'hEA);
            check_eq("post_rst_byte1", wr_log[1], 8'h90);
        end else check_eq("post_rst_wr", wr_log.size() >= 2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
